data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache_pkg.sv | 35 +++
 rtl/data_cache_array.sv | 51 +++++
 rtl/data_cache.sv | 211 +++++++++++++++++++++
 tb/tb_data_cache.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped, write-through data cache:
// FSM states, address-split widths and lane helpers.
package data_cache_pkg;

    localparam int ADDR_W      = 32;
    localparam int OFFSET_W    = 4;
    localparam int INDEX_W     = 6;
    localparam int TAG_W       = ADDR_W - OFFSET_W - INDEX_W;
    localparam int LINE_W      = 128;
    localparam int LINE_ADDR_W = ADDR_W - OFFSET_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        REFILL  = 3'd3,
        WR_REQ  = 3'd4
    } state_t;

    function automatic logic [31:0] word_select(input logic [LINE_W-1:0] line,
                                                input logic [1:0]        word);
        return line[{word, 5'b00000} +: 32];
    endfunction

    // Byte enables of one word moved to their lanes within a 16-byte line.
    function automatic logic [15:0] lane_mask(input logic [3:0] we,
                                              input logic [1:0] word);
        return {12'h000, we} << {word, 2'b00};
    endfunction

    function automatic logic [LINE_W-1:0] replicate_word(input logic [31:0] din);
        return {4{din}};
    endfunction

endpackage

// File: rtl/data_cache_array.sv
// Tag, valid and data storage for the data cache; combinational lookup,
// byte-masked writes, valid bits are the only reset state.
module data_cache_array
    import data_cache_pkg::*;
#(
    parameter int LINES    = 64,
    parameter int IDX_W    = 6,
    parameter int TAG_BITS = 22
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_W-1:0]    index,
    input  logic [TAG_BITS-1:0] tag,
    input  logic [15:0]         wr_mask,
    input  logic [LINE_W-1:0]   wr_data,
    input  logic                fill,
    output logic                hit,
    output logic [LINE_W-1:0]   rd_line
);

    logic [LINES-1:0]    valid_r;
    logic [TAG_BITS-1:0] tag_r  [LINES];
    logic [LINE_W-1:0]   data_r [LINES];

    assign hit     = valid_r[index] && (tag_r[index] == tag);
    assign rd_line = data_r[index];

    // Valid bits: cleared on reset, set when a line is refilled.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= {LINES{1'b0}};
        end else if (fill) begin
            valid_r[index] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and byte-enabled data storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_r[index] <= tag;
        end
        for (int b = 0; b < 16; b++) begin
            if (wr_mask[b]) begin
                data_r[index][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a single
// outstanding line-granular memory transaction.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int LINES      = 64,
    parameter int LINE_BYTES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            dcache_addr,
    input  logic                   dcache_re,
    input  logic [3:0]             dcache_we,
    input  logic [31:0]            dcache_din,
    output logic [31:0]            dcache_dout,
    output logic                   stall,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_rw,
    output logic [LINE_ADDR_W-1:0] mem_req_addr,
    output logic [LINE_W-1:0]      mem_req_data,
    output logic [15:0]            mem_req_mask,
    input  logic                   mem_resp_valid,
    input  logic [LINE_W-1:0]      mem_resp_data
);

    localparam int IDX_W     = $clog2(LINES);
    localparam int TAG_BITS  = ADDR_W - OFFSET_W - IDX_W;
    localparam int LINE_BITS = 8 * LINE_BYTES;

    state_t                 state_r;
    state_t                 state_s;
    logic [1:0]             word_s;
    logic [1:0]             word_r;
    logic [IDX_W-1:0]       req_index_s;
    logic [IDX_W-1:0]       arr_index_s;
    logic [TAG_BITS-1:0]    req_tag_s;
    logic [TAG_BITS-1:0]    arr_tag_s;
    logic                   is_write_s;
    logic                   hit_s;
    logic                   fill_s;
    logic                   arr_fill_s;
    logic [15:0]            wr_mask_s;
    logic [15:0]            arr_mask_s;
    logic [LINE_W-1:0]      wr_data_s;
    logic [LINE_W-1:0]      rd_line_s;
    logic [LINE_BITS-1:0]   refill_line_r;
    logic [LINE_ADDR_W-1:0] line_addr_r;
    logic [31:0]            dout_r;
    logic                   stall_r;
    logic                   mem_req_valid_r;
    logic                   mem_req_rw_r;
    logic [LINE_W-1:0]      mem_req_data_r;
    logic [15:0]            mem_req_mask_r;
    logic                   unused_s;

    assign word_s      = dcache_addr[3:2];
    assign req_index_s = dcache_addr[OFFSET_W +: IDX_W];
    assign req_tag_s   = dcache_addr[ADDR_W-1 -: TAG_BITS];
    assign is_write_s  = (dcache_we != 4'b0000);
    assign unused_s    = ^dcache_addr[1:0];

    // During REFILL the array follows the captured miss address, not the live request.
    assign arr_index_s = (state_r == REFILL) ? line_addr_r[IDX_W-1:0] : req_index_s;
    assign arr_tag_s   = (state_r == REFILL) ? line_addr_r[LINE_ADDR_W-1 -: TAG_BITS] : req_tag_s;
    assign arr_mask_s  = reset ? 16'h0000 : wr_mask_s;
    assign arr_fill_s  = fill_s & ~reset;

    data_cache_array #(
        .LINES    (LINES),
        .IDX_W    (IDX_W),
        .TAG_BITS (TAG_BITS)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .index   (arr_index_s),
        .tag     (arr_tag_s),
        .wr_mask (arr_mask_s),
        .wr_data (wr_data_s),
        .fill    (arr_fill_s),
        .hit     (hit_s),
        .rd_line (rd_line_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and array write controls.
    always_comb begin
        state_s   = state_r;
        wr_mask_s = 16'h0000;
        wr_data_s = replicate_word(dcache_din);
        fill_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (is_write_s) begin
                    state_s = WR_REQ;
                    if (hit_s) begin
                        wr_mask_s = lane_mask(dcache_we, word_s);
                    end else begin
                        wr_mask_s = 16'h0000;
                    end
                end else if (dcache_re && !hit_s) begin
                    state_s = RD_REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_REQ: begin
                if (mem_req_valid_r && mem_req_ready) begin
                    state_s = RD_WAIT;
                end else begin
                    state_s = RD_REQ;
                end
            end
            RD_WAIT: begin
                if (mem_resp_valid) begin
                    state_s = REFILL;
                end else begin
                    state_s = RD_WAIT;
                end
            end
            REFILL: begin
                state_s   = IDLE;
                fill_s    = 1'b1;
                wr_mask_s = 16'hFFFF;
                wr_data_s = refill_line_r;
            end
            WR_REQ: begin
                if (mem_req_valid_r && mem_req_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = WR_REQ;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Registered outputs, request capture and refill line latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req_valid_r <= 1'b0;
            stall_r         <= 1'b0;
            dout_r          <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (is_write_s) begin
                        mem_req_valid_r <= 1'b1;
                        mem_req_rw_r    <= 1'b1;
                        line_addr_r     <= dcache_addr[ADDR_W-1:OFFSET_W];
                        mem_req_data_r  <= replicate_word(dcache_din);
                        mem_req_mask_r  <= lane_mask(dcache_we, word_s);
                        stall_r         <= 1'b1;
                    end else if (dcache_re) begin
                        if (hit_s) begin
                            dout_r <= word_select(rd_line_s, word_s);
                        end else begin
                            mem_req_valid_r <= 1'b1;
                            mem_req_rw_r    <= 1'b0;
                            line_addr_r     <= dcache_addr[ADDR_W-1:OFFSET_W];
                            mem_req_mask_r  <= 16'h0000;
                            word_r          <= word_s;
                            stall_r         <= 1'b1;
                        end
                    end
                end
                RD_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_r <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    // Load data and the stall release land together in the REFILL cycle.
                    if (mem_resp_valid) begin
                        refill_line_r <= mem_resp_data;
                        dout_r        <= word_select(mem_resp_data, word_r);
                        stall_r       <= 1'b0;
                    end
                end
                WR_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_r <= 1'b0;
                        stall_r         <= 1'b0;
                    end
                end
                default: begin
                    stall_r <= 1'b0;
                end
            endcase
        end
    end

    assign dcache_dout   = dout_r;
    assign stall         = stall_r;
    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_rw    = mem_req_rw_r;
    assign mem_req_addr  = line_addr_r;
    assign mem_req_data  = mem_req_data_r;
    assign mem_req_mask  = mem_req_mask_r;

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: vector table driven through a
// write-through memory model, expected load data scoreboarded in a queue.
module tb_data_cache;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  dcache_addr;
    logic         dcache_re;
    logic [3:0]   dcache_we;
    logic [31:0]  dcache_din;
    logic [31:0]  dcache_dout;
    logic         stall;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rw;
    logic [27:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic [15:0]  mem_req_mask;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;

    always #5 clk = ~clk;

    data_cache #(.LINES(64), .LINE_BYTES(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .dcache_addr    (dcache_addr),
        .dcache_re      (dcache_re),
        .dcache_we      (dcache_we),
        .dcache_din     (dcache_din),
        .dcache_dout    (dcache_dout),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_mask   (mem_req_mask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    typedef struct {
        bit          wr;
        bit          re;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] din;
        bit          exp_hit;
        logic [15:0] exp_mask;
        int          ready_dly;
        int          resp_dly;
    } vec_t;

    vec_t        vecs [18];
    logic [31:0] ref_mem [logic [29:0]];
    logic [31:0] exp_q [$];
    logic [31:0] last_dout;
    int          checks = 0;
    int          errors = 0;

    function automatic vec_t mk_rd(input logic [31:0] addr, input bit hit,
                                   input int rdy, input int rsp);
        vec_t v;
        v.wr = 1'b0; v.re = 1'b1; v.addr = addr; v.we = 4'b0000; v.din = 32'h0;
        v.exp_hit = hit; v.exp_mask = 16'h0000; v.ready_dly = rdy; v.resp_dly = rsp;
        return v;
    endfunction

    function automatic vec_t mk_wr(input logic [31:0] addr, input logic [3:0] we,
                                   input logic [31:0] din, input bit re,
                                   input logic [15:0] mask, input int rdy);
        vec_t v;
        v.wr = 1'b1; v.re = re; v.addr = addr; v.we = we; v.din = din;
        v.exp_hit = 1'b0; v.exp_mask = mask; v.ready_dly = rdy; v.resp_dly = 1;
        return v;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] addr);
        logic [29:0] wa;
        wa = addr[31:2];
        if (ref_mem.exists(wa)) return ref_mem[wa];
        return {wa[15:0], wa[15:0] ^ 16'h5A5A};
    endfunction

    task automatic ref_write(input logic [31:0] addr, input logic [3:0] we,
                             input logic [31:0] din);
        logic [31:0] w;
        w = ref_read(addr);
        for (int b = 0; b < 4; b++) begin
            if (we[b]) w[8*b +: 8] = din[8*b +: 8];
        end
        ref_mem[addr[31:2]] = w;
    endtask

    function automatic logic [127:0] ref_line(input logic [27:0] la);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) begin
            l[32*w +: 32] = ref_read({la, w[1:0], 2'b00});
        end
        return l;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the read request in RD_REQ for ready_dly cycles, then answer resp_dly cycles after the handshake.
    task automatic serve_read(input string tag, input logic [27:0] la,
                              input int ready_dly, input int resp_dly);
        for (int i = 0; i <= ready_dly; i++) begin
            check({tag, "_rdreq_valid"}, mem_req_valid, 1'b1);
            check({tag, "_rdreq_rw"}, mem_req_rw, 1'b0);
            check({tag, "_rdreq_addr"}, mem_req_addr, la);
            check({tag, "_rdreq_stall"}, stall, 1'b1);
            mem_req_ready = (i == ready_dly);
            tick();
        end
        mem_req_ready = 1'b0;
        for (int i = 1; i < resp_dly; i++) begin
            check({tag, "_rdwait_stall"}, stall, 1'b1);
            check({tag, "_rdwait_valid"}, mem_req_valid, 1'b0);
            tick();
        end
        check({tag, "_rdwait_stall"}, stall, 1'b1);
        mem_resp_data  = ref_line(la);
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_data  = 128'h0;
    endtask

    task automatic serve_write(input string tag, input logic [27:0] la,
                               input logic [127:0] data, input logic [15:0] mask,
                               input int ready_dly);
        for (int i = 0; i <= ready_dly; i++) begin
            check({tag, "_wr_valid"}, mem_req_valid, 1'b1);
            check({tag, "_wr_rw"}, mem_req_rw, 1'b1);
            check({tag, "_wr_addr"}, mem_req_addr, la);
            check({tag, "_wr_data"}, mem_req_data, data);
            check({tag, "_wr_mask"}, mem_req_mask, mask);
            check({tag, "_wr_stall"}, stall, 1'b1);
            mem_req_ready = (i == ready_dly);
            tick();
        end
        mem_req_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        string       tag;
        logic [31:0] exp_word;
        tag = $sformatf("v%0d", n);
        dcache_addr = v.addr;
        dcache_re   = v.re;
        dcache_we   = v.wr ? v.we : 4'b0000;
        dcache_din  = v.din;
        if (v.wr) ref_write(v.addr, v.we, v.din);
        else      exp_q.push_back(ref_read(v.addr));
        tick();
        // Inputs are don't-care once captured; scramble them to prove it.
        dcache_re   = 1'b0;
        dcache_we   = 4'b0000;
        dcache_addr = 32'hA5A5_A5A4;
        dcache_din  = 32'h5A5A_5A5A;
        if (v.wr) begin
            serve_write(tag, v.addr[31:4], {4{v.din}}, v.exp_mask, v.ready_dly);
            check({tag, "_wr_done_stall"}, stall, 1'b0);
            check({tag, "_wr_done_valid"}, mem_req_valid, 1'b0);
            check({tag, "_dout_hold"}, dcache_dout, last_dout);
        end else begin
            check({tag, "_hit"}, !stall, v.exp_hit);
            if (stall) serve_read(tag, v.addr[31:4], v.ready_dly, v.resp_dly);
            check({tag, "_ld_stall"}, stall, 1'b0);
            check({tag, "_ld_valid"}, mem_req_valid, 1'b0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_scoreboard: got empty queue expected one entry", tag);
            end else begin
                exp_word = exp_q.pop_front();
                check({tag, "_ld_data"}, dcache_dout, exp_word);
                last_dout = exp_word;
            end
            tick();
            check({tag, "_idle_stall"}, stall, 1'b0);
            check({tag, "_idle_valid"}, mem_req_valid, 1'b0);
            check({tag, "_idle_dout"}, dcache_dout, last_dout);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        reset          = 1'b1;
        dcache_addr    = 32'h0;
        dcache_re      = 1'b0;
        dcache_we      = 4'b0000;
        dcache_din     = 32'h0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 128'h0;
        last_dout      = 32'h0;

        ref_mem[30'h400] = 32'h2222_1111;
        ref_mem[30'h401] = 32'h4444_3333;
        ref_mem[30'h402] = 32'h6666_5555;
        ref_mem[30'h403] = 32'h8888_7777;

        vecs[0]  = mk_rd(32'h0000_1004, 1'b0, 1, 3);
        vecs[1]  = mk_rd(32'h0000_1004, 1'b1, 0, 1);
        vecs[2]  = mk_wr(32'h0000_1008, 4'b0011, 32'h0000_BEEF, 1'b0, 16'h0300, 2);
        vecs[3]  = mk_rd(32'h0000_1008, 1'b1, 0, 1);
        vecs[4]  = mk_wr(32'h0000_2008, 4'b1111, 32'hCAFE_F00D, 1'b0, 16'h0F00, 0);
        vecs[5]  = mk_rd(32'h0000_1008, 1'b1, 0, 1);
        vecs[6]  = mk_rd(32'h0000_2008, 1'b0, 0, 1);
        vecs[7]  = mk_rd(32'h0000_100C, 1'b0, 2, 2);
        vecs[8]  = mk_wr(32'h0000_1004, 4'b1100, 32'h1234_0000, 1'b0, 16'h00C0, 1);
        vecs[9]  = mk_rd(32'h0000_1004, 1'b1, 0, 1);
        vecs[10] = mk_rd(32'h0000_03FC, 1'b0, 0, 1);
        vecs[11] = mk_rd(32'h0000_03F0, 1'b1, 0, 1);
        vecs[12] = mk_wr(32'h0000_03F4, 4'b0100, 32'h00AB_0000, 1'b1, 16'h0040, 0);
        vecs[13] = mk_rd(32'h0000_03F4, 1'b1, 0, 1);
        vecs[14] = mk_wr(32'hFFFF_FFF0, 4'b0001, 32'h0000_00EE, 1'b0, 16'h0001, 1);
        vecs[15] = mk_rd(32'h0000_03F0, 1'b1, 0, 1);
        vecs[16] = mk_rd(32'hFFFF_FFFC, 1'b0, 10, 2);
        vecs[17] = mk_rd(32'h0000_03F0, 1'b0, 0, 1);

        tick();
        tick();
        reset = 1'b0;
        check("reset_stall", stall, 1'b0);
        check("reset_valid", mem_req_valid, 1'b0);
        check("reset_dout", dcache_dout, 32'h0);

        for (int n = 0; n < 18; n++) begin
            run_vec(vecs[n], n);
        end
        check("refill_word1", vecs[0].exp_hit ? 32'h0 : ref_read(32'h0000_1008), 32'h6666_BEEF);

        // Reset while waiting for a refill response, then a stray response.
        dcache_addr = 32'h0000_2008;
        dcache_re   = 1'b1;
        tick();
        dcache_re = 1'b0;
        check("rst_miss_stall", stall, 1'b1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("rst_rdwait_stall", stall, 1'b1);
        check("rst_rdwait_valid", mem_req_valid, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_abort_stall", stall, 1'b0);
        check("rst_abort_valid", mem_req_valid, 1'b0);
        check("rst_abort_dout", dcache_dout, 32'h0);
        mem_resp_data  = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        mem_resp_data  = 128'h0;
        check("stray_resp_stall", stall, 1'b0);
        check("stray_resp_dout", dcache_dout, 32'h0);
        tick();
        check("stray_resp_idle", stall, 1'b0);
        last_dout = 32'h0;
        run_vec(mk_rd(32'h0000_03F0, 1'b0, 0, 1), 18);
        run_vec(mk_rd(32'h0000_2008, 1'b0, 1, 2), 19);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
